// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bus of the JK bank arbiter: per-requester commands in,
// grant/status and the bank state out.
interface jk_bank_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [2*NREQ-1:0]    cmd_jk;
  logic [IDXW*NREQ-1:0] cmd_idx;
  logic [NREQ-1:0]      gnt;
  logic                 err;
  logic                 busy;
  logic [IDXW-1:0]      owner;
  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     q_bar;

  modport master (
    output req, lock, cmd_jk, cmd_idx,
    input  gnt, err, busy, owner, q, q_bar
  );

  modport slave (
    input  req, lock, cmd_jk, cmd_idx,
    output gnt, err, busy, owner, q, q_bar
  );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter with optional lock that applies one JK command per
// IDLE/APPLY pair to an embedded WIDTH-bit JK state bank.
module jk_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 3
) (
  input logic              clk,
  input logic              rst,
  jk_bank_arbiter_if.slave bus
);
  localparam int unsigned IdW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StApply} state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]   win_id_q, win_id_d;
  logic [IdW-1:0]   lock_id_q, lock_id_d;
  logic [IdW-1:0]   owner_q, owner_d;
  logic [1:0]       win_jk_q, win_jk_d;
  logic [IDXW-1:0]  win_idx_q, win_idx_d;
  logic             lock_held_q, lock_held_d;
  logic [WIDTH-1:0] q_q, q_d;

  logic             idx_oob;
  logic             lock_active;
  logic             found;
  logic [IdW-1:0]   cand;
  int unsigned      k;

  assign idx_oob = 32'(win_idx_q) >= WIDTH;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    win_id_d    = win_id_q;
    lock_id_d   = lock_id_q;
    owner_d     = owner_q;
    win_jk_d    = win_jk_q;
    win_idx_d   = win_idx_q;
    lock_held_d = lock_held_q;
    q_d         = q_q;
    lock_active = 1'b0;
    found       = 1'b0;
    cand        = '0;
    k           = 0;

    // The lock only counts while its owner still requests; otherwise fall back to round-robin.
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (lock_held_q && (lock_id_q == IdW'(r)) && bus.req[r]) lock_active = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        lock_held_d = lock_active;
        if (lock_active) begin
          found = 1'b1;
          cand  = lock_id_q;
        end else begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(rr_ptr_q) + i) % NREQ;
            if (!found && bus.req[IdW'(k)]) begin
              found = 1'b1;
              cand  = IdW'(k);
            end
          end
        end
        if (found) begin
          win_id_d = cand;
          for (int unsigned r = 0; r < NREQ; r++) begin
            if (cand == IdW'(r)) begin
              win_jk_d  = bus.cmd_jk[2*r +: 2];
              win_idx_d = bus.cmd_idx[IDXW*r +: IDXW];
            end
          end
          state_d = StApply;
        end
      end
      StApply: begin
        for (int unsigned b = 0; b < WIDTH; b++) begin
          if (!idx_oob && (32'(win_idx_q) == b)) begin
            unique case (win_jk_q)
              2'b00: q_d[b] = q_q[b];
              2'b01: q_d[b] = 1'b0;
              2'b10: q_d[b] = 1'b1;
              2'b11: q_d[b] = ~q_q[b];
            endcase
          end
        end
        for (int unsigned r = 0; r < NREQ; r++) begin
          if (win_id_q == IdW'(r)) lock_held_d = bus.lock[r];
        end
        lock_id_d = win_id_q;
        rr_ptr_d  = IdW'((32'(win_id_q) + 1) % NREQ);
        owner_d   = win_id_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.gnt = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      bus.gnt[r] = (state_q == StApply) && (win_id_q == IdW'(r));
    end
  end

  assign bus.busy  = (state_q == StApply);
  assign bus.err   = (state_q == StApply) && idx_oob;
  assign bus.owner = IDXW'(owner_q);
  assign bus.q     = q_q;
  assign bus.q_bar = ~q_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      win_id_q    <= '0;
      lock_id_q   <= '0;
      owner_q     <= '0;
      win_jk_q    <= '0;
      win_idx_q   <= '0;
      lock_held_q <= 1'b0;
      q_q         <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      win_id_q    <= win_id_d;
      lock_id_q   <= lock_id_d;
      owner_q     <= owner_d;
      win_jk_q    <= win_jk_d;
      win_idx_q   <= win_idx_d;
      lock_held_q <= lock_held_d;
      q_q         <= q_d;
    end
  end
endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter: an 8-bit bank instance for arbitration,
// lock and reset behaviour, and a 6-bit instance for out-of-range indices.
module tb_jk_bank_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jk_bank_arbiter_if #(.NREQ(4), .WIDTH(8), .IDXW(3)) bus8 ();
  jk_bank_arbiter_if #(.NREQ(4), .WIDTH(6), .IDXW(3)) bus6 ();

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One IDLE->APPLY->IDLE command on the 8-bit instance.
  task automatic step(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                      input logic [2:0] eo);
    tick();
    chk({tag, "_gnt"}, 32'(bus8.gnt), 32'(eg));
    chk({tag, "_busy"}, 32'(bus8.busy), 32'd1);
    chk({tag, "_err"}, 32'(bus8.err), 32'd0);
    tick();
    chk({tag, "_gnt_idle"}, 32'(bus8.gnt), 32'd0);
    chk({tag, "_busy_idle"}, 32'(bus8.busy), 32'd0);
    chk({tag, "_q"}, 32'(bus8.q), 32'(eq));
    chk({tag, "_owner"}, 32'(bus8.owner), 32'(eo));
  endtask

  initial begin
    bus8.req = '0; bus8.lock = '0; bus8.cmd_jk = '0; bus8.cmd_idx = '0;
    bus6.req = '0; bus6.lock = '0; bus6.cmd_jk = '0; bus6.cmd_idx = '0;

    tick();
    chk("rst_q", 32'(bus8.q), 32'h00);
    chk("rst_qbar", 32'(bus8.q_bar), 32'hFF);
    chk("rst_gnt", 32'(bus8.gnt), 32'h0);
    chk("rst_busy", 32'(bus8.busy), 32'h0);
    chk("rst_err", 32'(bus8.err), 32'h0);
    chk("rst_owner", 32'(bus8.owner), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Contention: everyone sets its own bit; rr_ptr starts at 0.
    bus8.req     = 4'b1111;
    bus8.cmd_jk  = 8'b10_10_10_10;
    bus8.cmd_idx = {3'd3, 3'd2, 3'd1, 3'd0};
    step("cont0", 4'b0001, 8'h01, 3'd0);
    step("cont1", 4'b0010, 8'h03, 3'd1);
    step("cont2", 4'b0100, 8'h07, 3'd2);
    step("cont3", 4'b1000, 8'h0F, 3'd3);
    bus8.req = '0;
    tick();

    // Reset during APPLY of a set of bit 5 by requester 1.
    bus8.req     = 4'b0010;
    bus8.cmd_jk  = 8'b00_00_10_00;
    bus8.cmd_idx = {3'd0, 3'd0, 3'd5, 3'd0};
    tick();
    chk("mid_gnt_pre", 32'(bus8.gnt), 32'b0010);
    rst = 1'b1;
    bus8.req = '0;
    #2;
    chk("mid_q_async", 32'(bus8.q), 32'h00);
    chk("mid_qbar_async", 32'(bus8.q_bar), 32'hFF);
    chk("mid_gnt_async", 32'(bus8.gnt), 32'h0);
    chk("mid_busy_async", 32'(bus8.busy), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_gnt_post", 32'(bus8.gnt), 32'h0);
    chk("mid_busy_post", 32'(bus8.busy), 32'h0);
    tick();
    chk("mid_gnt_post2", 32'(bus8.gnt), 32'h0);
    chk("mid_q_post", 32'(bus8.q), 32'h00);
    chk("mid_owner_post", 32'(bus8.owner), 32'h0);

    // Single requester toggles bit 3 twice.
    bus8.req     = 4'b0001;
    bus8.cmd_jk  = 8'b00_00_00_11;
    bus8.cmd_idx = {3'd0, 3'd0, 3'd0, 3'd3};
    step("tog1", 4'b0001, 8'h08, 3'd0);
    step("tog2", 4'b0001, 8'h00, 3'd0);
    bus8.req = '0;
    tick();

    // Lock: requester 2 holds the bank while requester 1 waits.
    bus8.req     = 4'b0100;
    bus8.lock    = 4'b0100;
    bus8.cmd_jk  = 8'b00_10_10_00;
    bus8.cmd_idx = {3'd0, 3'd0, 3'd7, 3'd0};
    step("lock1", 4'b0100, 8'h01, 3'd2);
    bus8.req = 4'b0110;
    bus8.cmd_idx = {3'd0, 3'd1, 3'd7, 3'd0};
    step("lock2", 4'b0100, 8'h03, 3'd2);
    bus8.cmd_idx = {3'd0, 3'd2, 3'd7, 3'd0};
    step("lock3", 4'b0100, 8'h07, 3'd2);
    bus8.lock    = 4'b0000;
    bus8.cmd_jk  = 8'b00_11_10_00;
    bus8.cmd_idx = {3'd0, 3'd0, 3'd7, 3'd0};
    step("unlock", 4'b0100, 8'h06, 3'd2);
    bus8.req = 4'b0010;
    step("waiter", 4'b0010, 8'h86, 3'd1);
    bus8.req = '0;
    tick();

    // Out-of-range index on the 6-bit bank.
    bus6.req     = 4'b0001;
    bus6.cmd_jk  = 8'b00_00_00_10;
    bus6.cmd_idx = {3'd0, 3'd0, 3'd0, 3'd7};
    tick();
    chk("oob_gnt", 32'(bus6.gnt), 32'b0001);
    chk("oob_err", 32'(bus6.err), 32'd1);
    chk("oob_busy", 32'(bus6.busy), 32'd1);
    bus6.cmd_idx = {3'd0, 3'd0, 3'd0, 3'd5};
    tick();
    chk("oob_err_clr", 32'(bus6.err), 32'd0);
    chk("oob_q", 32'(bus6.q), 32'h00);
    chk("oob_qbar", 32'(bus6.q_bar), 32'h3F);
    tick();
    chk("w6_gnt", 32'(bus6.gnt), 32'b0001);
    chk("w6_err", 32'(bus6.err), 32'd0);
    bus6.req = '0;
    tick();
    chk("w6_q", 32'(bus6.q), 32'h20);
    chk("w6_qbar", 32'(bus6.q_bar), 32'h1F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Shared-access controller for a bank of JK-style state bits. Up to NREQ requesters each issue JK commands (hold, clear, set, toggle) against one bit of a WIDTH-bit register bank. Commands are arbitrated round-robin and applied one at a time. An optional lock lets a requester hold the bank for back-to-back commands. The block sits between control-path requesters and the JK state bank, and the JK bank is embedded inside it.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of JK bits in the bank
- IDXW, 3, bit-index width; must satisfy 2**IDXW >= WIDTH

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester command request; level, held until granted
- lock  in  NREQ  per-requester lock; sampled only in APPLY for the current winner
- cmd_jk  in  2*NREQ  per-requester {j,k}; requester r uses bits [2r+1:2r]
- cmd_idx  in  IDXW*NREQ  per-requester target bit index; requester r uses slice r
- gnt  out  NREQ  one-hot acknowledge, high for exactly one cycle (APPLY) per command
- err  out  1  high in the APPLY cycle when the granted index is >= WIDTH
- busy  out  1  high while state is APPLY
- owner  out  IDXW  index of the last granted requester, held between grants
- q  out  WIDTH  JK bank state
- q_bar  out  WIDTH  bitwise inverse of q, combinational

## Operation
- FSM states: IDLE, APPLY.
- **IDLE, with eligible req bits:**
  - With no lock held, the winner is the first set req bit searching upward from rr_ptr, wrapping modulo NREQ.
  - With a lock held, only the lock owner is eligible. Other requests wait.
  - The winner's cmd_jk, cmd_idx and id are latched. Next state is APPLY.
- **IDLE, no eligible req:** stay in IDLE. q holds.
- **APPLY:**
  - gnt[winner]=1 and busy=1 for this cycle.
  - On the clock edge ending APPLY, q[idx] updates per the JK rule:
    - 00: hold
    - 01: q[idx] <= 0
    - 10: q[idx] <= 1
    - 11: q[idx] <= ~q[idx]
  - All other bits hold.
  - idx >= WIDTH: q unchanged, err=1. gnt is still issued and the command is consumed.
  - rr_ptr <= (winner+1) mod NREQ.
  - owner <= winner.
  - Lock: lock_held <= lock[winner], lock_id <= winner.
  - Next state is always IDLE.
- **Requester protocol:**
  - req, cmd_jk and cmd_idx must be stable from assertion until the cycle in which gnt is high.
  - The requester may change them, or drop req, on the edge closing that cycle.
  - The IDLE cycle that follows sees the updated values.
- Lock release: the owner issues a command with lock=0, or deasserts req while in IDLE. If the lock owner's req is low in IDLE, lock_held clears and normal round-robin resumes in the same cycle.
- Only the arbitrated command path modifies q. There is no direct write.

## Timing
- Throughput: one command per 2 cycles (IDLE, APPLY).
- Latency: the bit update is visible on q 2 cycles after req is sampled high in IDLE with no contention.
- Reset values:
  - state=IDLE, q=0, q_bar all ones
  - gnt=0, err=0, busy=0, owner=0
  - rr_ptr=0, lock_held=0
- Reset asserted during APPLY: the command is dropped, q is forced to 0, and no gnt follows after reset releases.
- Outputs:
  - gnt, busy and err are decoded from state and the latched winner. They are glitch-free relative to clk.
  - q is registered.
- Simultaneous requests: at most one gnt per APPLY. Losers are not acknowledged and must keep req high.
- Wrap-around: with winner=NREQ-1, rr_ptr wraps to 0.

## Test plan
- **Reset:** assert rst mid-run → q=8'h00, q_bar=8'hFF, gnt=0, busy=0 immediately, without waiting for a clock edge.
- **Single toggle:** req[0], cmd_jk=11, idx=3 twice.
  - First command → gnt[0] pulse, q=8'h08.
  - Second command → q=8'h00.
  - Each command is acknowledged 1 cycle after IDLE.
- **Contention:** req=4'b1111 held, every requester sets bit r.
  - Grants follow the order 0,1,2,3, with rr_ptr starting at 0.
  - Final q=8'h0F after 8 cycles.
- **Lock:** req[2] with lock=1 issues 3 commands while req[1] is held high.
  - No gnt[1] until req[2] issues its lock=0 command.
  - gnt[1] follows in the next APPLY.
- **Out of range:** WIDTH=6, idx=7, cmd 10 → gnt pulse, err=1 for that cycle, q unchanged.
- **Reset mid-APPLY:** pulse rst during a granted set of bit 5 → q=0, no gnt after release, state=IDLE.
